// File: rtl/cc_line_fill.sv
// Cache line fill: collects 8 x 64-bit beats into a line, then pushes {offset, 3'b0, line} to a FIFO.
// Write strobe comes the cycle after beat 7; a full FIFO holds the entry and blocks new misses.
module cc_line_fill (
  input  logic         clk,
  input  logic         rst,
  input  logic         miss_valid_i,
  input  logic [2:0]   miss_offset_i,
  output logic         miss_ready_o,
  input  logic [63:0]  mem_rdata_i,
  input  logic         mem_rvalid_i,
  input  logic         mem_rlast_i,
  output logic         mem_rready_o,
  input  logic         fifo_full_i,
  output logic         fifo_wren_o,
  output logic [517:0] fifo_wdata_o,
  output logic         fill_done_o,
  output logic         err_o
);

  typedef enum logic [1:0] {IDLE, FILL, PUSH} state_t;

  state_t       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [511:0] line_q, line_d;
  logic [2:0]   offset_q, offset_d;
  logic         err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      line_q   <= '0;
      offset_q <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      line_q   <= line_d;
      offset_q <= offset_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    offset_d     = offset_q;
    err_d        = err_q;
    miss_ready_o = 1'b0;
    mem_rready_o = 1'b0;
    fifo_wren_o  = 1'b0;
    case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          offset_d = miss_offset_i;
          line_d   = '0;
          cnt_d    = 3'd0;
          state_d  = FILL;
        end
      end
      FILL: begin
        mem_rready_o = 1'b1;
        if (mem_rvalid_i) begin
          // Beat k lands at bit 64*(7-k); ~cnt_q is 7-k.
          line_d[{~cnt_q, 6'd0} +: 64] = mem_rdata_i;
          cnt_d = cnt_q + 3'd1;
          if ((cnt_q == 3'd7) != mem_rlast_i) err_d = 1'b1;
          if (cnt_q == 3'd7) state_d = PUSH;
        end
      end
      PUSH: begin
        fifo_wren_o = !fifo_full_i;
        if (!fifo_full_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_done_o  = fifo_wren_o;
  assign fifo_wdata_o = {offset_q, 3'b000, line_q};
  assign err_o        = err_q;

endmodule

// File: tb/tb_cc_line_fill.sv
// Randomized and directed line-fill transactions against a transaction-level model.
module tb_cc_line_fill;
  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid_i;
  logic [2:0]   miss_offset_i;
  logic         miss_ready_o;
  logic [63:0]  mem_rdata_i;
  logic         mem_rvalid_i;
  logic         mem_rlast_i;
  logic         mem_rready_o;
  logic         fifo_full_i;
  logic         fifo_wren_o;
  logic [517:0] fifo_wdata_o;
  logic         fill_done_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int exp_wr = 0;
  bit err_m  = 1'b0;

  cc_line_fill dut (
    .clk(clk), .rst(rst),
    .miss_valid_i(miss_valid_i), .miss_offset_i(miss_offset_i), .miss_ready_o(miss_ready_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .mem_rlast_i(mem_rlast_i),
    .mem_rready_o(mem_rready_o), .fifo_full_i(fifo_full_i), .fifo_wren_o(fifo_wren_o),
    .fifo_wdata_o(fifo_wdata_o), .fill_done_o(fill_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    if (fifo_wren_o) wr_cnt++;
  end

  task automatic check(input string tag, input logic [517:0] obs, input logic [517:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One full miss: handshake, 8 beats, optional FIFO-full stall, write. Starts and ends at a negedge in IDLE.
  task automatic txn(input logic [2:0] off, input bit seq, input int gap, input int full_n,
                     input int last_beat, input bit hold);
    logic [63:0]  beats [8];
    logic [511:0] exp_line;
    logic [517:0] exp_ent;
    int g;
    bit last;
    exp_line = '0;
    for (int k = 0; k < 8; k++) begin
      beats[k] = seq ? 64'(k) : rnd64();
      exp_line = {exp_line[447:0], beats[k]};
    end
    exp_ent = {off, 3'b000, exp_line};

    miss_valid_i  = 1'b1;
    miss_offset_i = off;
    mem_rvalid_i  = 1'($urandom_range(0, 1));
    mem_rdata_i   = rnd64();
    mem_rlast_i   = 1'($urandom_range(0, 1));
    fifo_full_i   = 1'b0;
    #1;
    check("idle_miss_ready", 518'(miss_ready_o), 518'(1));
    check("idle_mem_rready", 518'(mem_rready_o), 518'(0));
    @(negedge clk);
    miss_valid_i  = hold;
    miss_offset_i = hold ? 3'd6 : 3'($urandom);

    for (int k = 0; k < 8; k++) begin
      g = (gap < 0) ? $urandom_range(0, 2) : gap;
      repeat (g) begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = rnd64();
        mem_rlast_i  = 1'($urandom_range(0, 1));
        #1;
        check("fill_mem_rready", 518'(mem_rready_o), 518'(1));
        check("fill_miss_ready", 518'(miss_ready_o), 518'(0));
        @(negedge clk);
      end
      last = (k == last_beat);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = beats[k];
      mem_rlast_i  = last;
      if (last != (k == 7)) err_m = 1'b1;
      #1;
      check("beat_wren", 518'(fifo_wren_o), 518'(0));
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      mem_rlast_i  = 1'b0;
      #1;
      check("err_after_beat", 518'(err_o), 518'(err_m));
    end

    repeat (full_n) begin
      fifo_full_i  = 1'b1;
      mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_rdata_i  = rnd64();
      #1;
      check("full_wren", 518'(fifo_wren_o), 518'(0));
      check("full_wdata_stable", fifo_wdata_o, exp_ent);
      check("push_mem_rready", 518'(mem_rready_o), 518'(0));
      @(negedge clk);
    end
    fifo_full_i  = 1'b0;
    mem_rvalid_i = 1'($urandom_range(0, 1));
    mem_rdata_i  = rnd64();
    #1;
    check("push_wren", 518'(fifo_wren_o), 518'(1));
    check("push_fill_done", 518'(fill_done_o), 518'(1));
    check("push_wdata", fifo_wdata_o, exp_ent);
    check("push_err", 518'(err_o), 518'(err_m));
    check("push_miss_ready", 518'(miss_ready_o), 518'(0));
    exp_wr++;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
  endtask

  // Start a fill, deliver some beats, then pulse reset mid-fill.
  task automatic reset_mid_fill(input logic [2:0] off, input int nbeats);
    miss_valid_i  = 1'b1;
    miss_offset_i = off;
    @(negedge clk);
    miss_valid_i = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rnd64();
      mem_rlast_i  = 1'b0;
      @(negedge clk);
    end
    mem_rvalid_i = 1'b0;
    rst = 1'b1;
    err_m = 1'b0;
    #1;
    check("rst_miss_ready", 518'(miss_ready_o), 518'(1));
    check("rst_mem_rready", 518'(mem_rready_o), 518'(0));
    check("rst_wren", 518'(fifo_wren_o), 518'(0));
    check("rst_wdata", fifo_wdata_o, 518'(0));
    check("rst_err", 518'(err_o), 518'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    miss_valid_i = 1'b0; miss_offset_i = 3'd0;
    mem_rdata_i = '0; mem_rvalid_i = 1'b0; mem_rlast_i = 1'b0;
    fifo_full_i = 1'b0;
    #1;
    check("reset_miss_ready", 518'(miss_ready_o), 518'(1));
    check("reset_mem_rready", 518'(mem_rready_o), 518'(0));
    check("reset_wren", 518'(fifo_wren_o), 518'(0));
    check("reset_fill_done", 518'(fill_done_o), 518'(0));
    check("reset_err", 518'(err_o), 518'(0));
    check("reset_wdata", fifo_wdata_o, 518'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    txn(3'd3, 1'b1, 0, 0, 7, 1'b0);   // back-to-back, FIFO empty
    txn(3'd3, 1'b1, 0, 5, 7, 1'b0);   // FIFO full for 5 cycles
    txn(3'd3, 1'b1, 2, 0, 7, 1'b0);   // 2-cycle gaps between beats
    txn(3'd2, 1'b0, 0, 0, 4, 1'b0);   // early rlast on beat 4
    txn(3'd4, 1'b0, -1, 1, 7, 1'b0);  // err stays sticky
    reset_mid_fill(3'd7, 4);
    txn(3'd5, 1'b0, 0, 0, 7, 1'b0);   // fresh line after reset
    txn(3'd1, 1'b0, 0, 0, 7, 1'b1);   // miss held high with offset 6
    txn(3'd6, 1'b0, 0, 0, 7, 1'b0);   // accepted the cycle after the write

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) begin
        miss_valid_i = 1'b0;
        mem_rvalid_i = 1'($urandom_range(0, 1));
        mem_rdata_i  = rnd64();
        #1;
        check("gap_miss_ready", 518'(miss_ready_o), 518'(1));
        @(negedge clk);
      end
      txn(3'($urandom), 1'b0, -1, $urandom_range(0, 3),
          ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : 7, 1'b0);
    end

    @(negedge clk);
    check("write_count", 518'(wr_cnt), 518'(exp_wr));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
